bow_draw_ctrl: RTL

//  Sequences the bow sprite through its draw frames (bow_0..bow_N-1) from player input and releases arrows.

---
 rtl/bow_pkg.sv | 8 +
 rtl/bow_frame_timer.sv | 23 ++
 rtl/bow_draw_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bow_pkg.sv
// Shared types and defaults for the bow draw controller and its frame timers.
package bow_pkg;
   typedef enum logic [1:0] {IDLE, DRAW, FULL, COOLDOWN} bow_state_t;

   localparam int NUM_BOW_FRAMES = 3;
   localparam int BOW_SEL_W      = $clog2(NUM_BOW_FRAMES);
   localparam int DEF_POWER_W    = 4;
endpackage

// File: rtl/bow_frame_timer.sv
// Frame-gated up counter with synchronous clear and a terminal-count flag.
// Wraps to zero on the increment taken at terminal count.
module bow_frame_timer #(
   parameter int TERM = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_tc
);
   localparam int W = $clog2(TERM + 1);

   logic [W-1:0] r_cnt;

   assign o_tc = (r_cnt == W'(TERM - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_cnt <= '0;
      else if (i_clr)   r_cnt <= '0;
      else if (i_inc)   r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
   end
endmodule

// File: rtl/bow_draw_ctrl.sv
// Bow draw sequencer: steps sprite frames while the button is held and fires on release.
// Optional BOW_AUTOFIRE_EN forces a full-power release after HOLD_LIMIT held frames in FULL.
module bow_draw_ctrl
   import bow_pkg::*;
#(
   parameter int NUM_FRAMES      = NUM_BOW_FRAMES,
   parameter int TICKS_PER_STAGE = 20,
   parameter int COOLDOWN_FRAMES = 15,
   parameter int POWER_W         = DEF_POWER_W,
   parameter int HOLD_LIMIT      = 60
) (
   input  logic                          vga_clk,
   input  logic                          reset_n,
   input  logic                          frame_start,
   input  logic                          btn_held,
   input  logic                          arrow_busy,
   output logic [$clog2(NUM_FRAMES)-1:0] bow_sel,
   output logic                          charging,
   output logic                          fire,
   output logic [POWER_W-1:0]            fire_power
);
   localparam int SEL_W    = $clog2(NUM_FRAMES);
   localparam int TICK_TRM = (TICKS_PER_STAGE < 1) ? 1 : TICKS_PER_STAGE;
   localparam int CD_TRM   = (COOLDOWN_FRAMES < 1) ? 1 : COOLDOWN_FRAMES;
   localparam logic [SEL_W-1:0]   STAGE_MAX = SEL_W'(NUM_FRAMES - 1);
   localparam logic [POWER_W-1:0] PWR_MAX   = '1;

   bow_state_t         r_state, w_nstate;
   logic [SEL_W-1:0]   r_stage, w_nstage;
   logic [POWER_W-1:0] r_power, w_npower, w_pwr_inc;
   logic               r_fire, r_charging;
   logic [POWER_W-1:0] r_fire_power;
   logic               w_release, w_force;
   logic               w_tick_clr, w_tick_inc, w_tick_tc;
   logic               w_cd_clr, w_cd_inc, w_cd_tc;
   logic               w_hold_clr, w_hold_inc, w_hold_tc;

   assign w_pwr_inc = (r_power == PWR_MAX) ? r_power : r_power + 1'b1;

   bow_frame_timer #(.TERM(TICK_TRM)) u_tick (
      .clk(vga_clk), .rst_n(reset_n), .i_clr(w_tick_clr), .i_inc(w_tick_inc), .o_tc(w_tick_tc));

   bow_frame_timer #(.TERM(CD_TRM)) u_cd (
      .clk(vga_clk), .rst_n(reset_n), .i_clr(w_cd_clr), .i_inc(w_cd_inc), .o_tc(w_cd_tc));

`ifdef BOW_AUTOFIRE_EN
   localparam int HOLD_TRM = (HOLD_LIMIT < 1) ? 1 : HOLD_LIMIT;
   bow_frame_timer #(.TERM(HOLD_TRM)) u_hold (
      .clk(vga_clk), .rst_n(reset_n), .i_clr(w_hold_clr), .i_inc(w_hold_inc), .o_tc(w_hold_tc));
`else
   assign w_hold_tc = 1'b0;
`endif

   always_comb begin
      w_nstate   = r_state;
      w_nstage   = r_stage;
      w_npower   = r_power;
      w_release  = 1'b0;
      w_force    = 1'b0;
      w_tick_clr = 1'b0;
      w_tick_inc = 1'b0;
      w_cd_clr   = 1'b0;
      w_cd_inc   = 1'b0;
      w_hold_clr = 1'b0;
      w_hold_inc = 1'b0;
      if (frame_start) begin
         case (r_state)
            IDLE: begin
               if (btn_held && !arrow_busy) begin
                  // the arming frame already counts as one charged frame
                  w_nstate   = DRAW;
                  w_nstage   = '0;
                  w_npower   = POWER_W'(1);
                  w_tick_clr = 1'b1;
               end
            end
            DRAW: begin
               if (btn_held) begin
                  w_npower   = w_pwr_inc;
                  w_tick_inc = 1'b1;
                  if (w_tick_tc && r_stage < STAGE_MAX) begin
                     w_nstage = r_stage + 1'b1;
                     if (r_stage + 1'b1 == STAGE_MAX) begin
                        w_nstate   = FULL;
                        w_hold_clr = 1'b1;
                     end
                  end
               end else if (r_stage == '0) begin
                  w_nstate = IDLE;
               end else begin
                  w_release = 1'b1;
               end
            end
            FULL: begin
               if (btn_held) begin
                  w_npower   = w_pwr_inc;
                  w_hold_inc = 1'b1;
                  if (w_hold_tc) begin
                     w_release = 1'b1;
                     w_force   = 1'b1;
                  end
               end else begin
                  w_release = 1'b1;
               end
            end
            COOLDOWN: begin
               w_cd_inc = 1'b1;
               if (w_cd_tc) w_nstate = IDLE;
            end
            default: w_nstate = IDLE;
         endcase
         if (w_release) begin
            w_nstate = COOLDOWN;
            w_nstage = '0;
            w_cd_clr = 1'b1;
         end
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_stage      <= '0;
         r_power      <= '0;
         r_fire       <= 1'b0;
         r_fire_power <= '0;
         r_charging   <= 1'b0;
      end else begin
         r_state    <= w_nstate;
         r_stage    <= w_nstage;
         r_power    <= w_npower;
         r_charging <= (w_nstate == DRAW) || (w_nstate == FULL);
         r_fire     <= w_release && !arrow_busy;
         if (w_release && !arrow_busy)
            r_fire_power <= w_force ? PWR_MAX : r_power;
      end
   end

   // stage is forced to 0 outside DRAW/FULL, so it doubles as the sprite index
   assign bow_sel    = r_stage;
   assign charging   = r_charging;
   assign fire       = r_fire;
   assign fire_power = r_fire_power;
endmodule
